// File: rtl/ref_row_fetcher_if.sv
// Bus bundle between the reference row fetcher, its reference memory,
// the transposing window register and the interpolation filter.
interface ref_row_fetcher_if #(
    parameter int unsigned ADDR_W = 16
) ();
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] stride;
    logic              busy;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_rd_data;
    logic [63:0]       row_data;
    logic              row_load_L;
    logic [7:0]        row_idx;
    logic              window_valid;
    logic              window_ack;

    // Fetcher side
    modport master (
        input  start, base_addr, stride, mem_rd_data, window_ack,
        output busy, mem_rd_en, mem_addr, row_data, row_load_L, row_idx, window_valid
    );

    // Environment side: requester, memory, window register and filter
    modport slave (
        output start, base_addr, stride, mem_rd_data, window_ack,
        input  busy, mem_rd_en, mem_addr, row_data, row_load_L, row_idx, window_valid
    );
endinterface

// File: rtl/ref_row_fetcher.sv
// Fetches the ROWS reference rows of one 8x8 block from a fixed-latency memory,
// streams them into the window register and holds window_valid until acked.
module ref_row_fetcher #(
    parameter int unsigned ROWS   = 15,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RD_LAT = 2
) (
    input  logic             clock,
    input  logic             reset,
    ref_row_fetcher_if.master bus
);
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_n;
    logic [CNT_W-1:0]  ret_cnt_q;
    logic [ADDR_W-1:0] stride_q, stride_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic              rd_en_q, rd_en_n;
    logic              busy_q, busy_n;
    logic              wv_q, wv_n;
    logic [RD_LAT-1:0] tag_q;
    logic [63:0]       row_data_q;
    logic              row_load_L_q;
    logic [CNT_W-1:0]  row_idx_q;
    logic              last_row_c;

    assign last_row_c = !row_load_L_q && (row_idx_q == CNT_W'(ROWS - 1));

    // FSM and issue-side state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            stride_q    <= '0;
            addr_q      <= '0;
            rd_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            wv_q        <= 1'b0;
        end else begin
            state_q     <= state_n;
            issue_cnt_q <= issue_cnt_n;
            stride_q    <= stride_n;
            addr_q      <= addr_n;
            rd_en_q     <= rd_en_n;
            busy_q      <= busy_n;
            wv_q        <= wv_n;
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_n     = state_q;
        issue_cnt_n = issue_cnt_q;
        stride_n    = stride_q;
        addr_n      = addr_q;
        rd_en_n     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_n     = ISSUE;
                    stride_n    = bus.stride;
                    addr_n      = bus.base_addr;
                    rd_en_n     = 1'b1;
                    issue_cnt_n = CNT_W'(1);
                end
            end
            ISSUE: begin
                // issue_cnt_q counts requests already on the bus, including this cycle's
                if (issue_cnt_q == CNT_W'(ROWS)) begin
                    state_n = DRAIN;
                end else begin
                    rd_en_n     = 1'b1;
                    addr_n      = addr_q + stride_q;
                    issue_cnt_n = issue_cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (last_row_c) state_n = HOLD;
            end
            HOLD: begin
                if (bus.window_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
        wv_n   = (state_n == HOLD);
    end

    // Return path: a tag bit travels alongside each read so only tagged cycles load a row
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_q        <= '0;
            row_data_q   <= '0;
            row_load_L_q <= 1'b1;
            row_idx_q    <= '0;
            ret_cnt_q    <= '0;
        end else begin
            tag_q        <= (tag_q << 1) | RD_LAT'(rd_en_q);
            row_load_L_q <= 1'b1;
            if (tag_q[RD_LAT-1]) begin
                row_data_q   <= bus.mem_rd_data;
                row_load_L_q <= 1'b0;
                row_idx_q    <= ret_cnt_q;
                ret_cnt_q    <= ret_cnt_q + CNT_W'(1);
            end else if (state_q == IDLE) begin
                ret_cnt_q <= '0;
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.mem_rd_en    = rd_en_q;
    assign bus.mem_addr     = addr_q;
    assign bus.row_data     = row_data_q;
    assign bus.row_load_L   = row_load_L_q;
    assign bus.row_idx      = row_idx_q;
    assign bus.window_valid = wv_q;
endmodule

// File: tb/tb_ref_row_fetcher.sv
// Directed bench for ref_row_fetcher (RD_LAT=2) with a two-stage memory model
// returning each read address replicated four times across the 64-bit word.
module tb_ref_row_fetcher;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_mis = 0;
    logic [63:0] exp_row = '0;

    ref_row_fetcher_if #(.ADDR_W(16)) bus ();

    ref_row_fetcher #(.ROWS(15), .ADDR_W(16), .RD_LAT(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Memory: data for a read in cycle k is valid during cycle k+2, garbage otherwise
    logic        v1 = 1'b0, v2 = 1'b0;
    logic [15:0] a1 = '0,   a2 = '0;
    always @(posedge clock) begin
        v1 <= bus.mem_rd_en;
        a1 <= bus.mem_addr;
        v2 <= v1;
        a2 <= a1;
    end
    assign bus.mem_rd_data = v2 ? {4{a2}} : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"},      64'(bus.busy),         64'd0);
        chk({tag, " rd_en"},     64'(bus.mem_rd_en),    64'd0);
        chk({tag, " load_L"},    64'(bus.row_load_L),   64'd1);
        chk({tag, " valid"},     64'(bus.window_valid), 64'd0);
        chk({tag, " row_data"},  bus.row_data,          exp_row);
    endtask

    // One full fetch: start in the current cycle T, check every cycle T+1..T+19,
    // then HOLD for ack_dly cycles and ack (optionally with a simultaneous start).
    task automatic do_fetch(input logic [15:0] b, input logic [15:0] s,
                            input bit extra, input int ack_dly, input bit swa);
        logic [15:0] a;
        string t;
        bus.base_addr = b;
        bus.stride    = s;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.base_addr = 16'h5A5A;
        bus.stride    = 16'h1234;
        for (int o = 1; o <= 19; o++) begin
            t = $sformatf("b%h o%0d", b, o);
            chk({t, " busy"},  64'(bus.busy), 64'd1);
            chk({t, " rd_en"}, 64'(bus.mem_rd_en), 64'(o <= 15));
            if (o <= 15) begin
                a = b + 16'(o - 1) * s;
                chk({t, " addr"}, 64'(bus.mem_addr), 64'(a));
            end
            chk({t, " load_L"}, 64'(bus.row_load_L), 64'(!(o >= 4 && o <= 18)));
            if (o >= 4 && o <= 18) begin
                a = b + 16'(o - 4) * s;
                exp_row = {4{a}};
                chk({t, " idx"}, 64'(bus.row_idx), 64'(o - 4));
            end
            chk({t, " row_data"}, bus.row_data, exp_row);
            chk({t, " valid"}, 64'(bus.window_valid), 64'(o >= 19));
            bus.start      = extra && (o == 5 || o == 17);
            bus.window_ack = extra && (o == 10);
            tick();
        end
        bus.start      = 1'b0;
        bus.window_ack = 1'b0;
        for (int d = 0; d < ack_dly; d++) begin
            t = $sformatf("b%h hold%0d", b, d);
            chk({t, " valid"},    64'(bus.window_valid), 64'd1);
            chk({t, " busy"},     64'(bus.busy), 64'd1);
            chk({t, " load_L"},   64'(bus.row_load_L), 64'd1);
            chk({t, " row_data"}, bus.row_data, exp_row);
            tick();
        end
        chk($sformatf("b%h ackcyc valid", b), 64'(bus.window_valid), 64'd1);
        bus.window_ack = 1'b1;
        bus.start      = swa;
        tick();
        bus.window_ack = 1'b0;
        bus.start      = 1'b0;
        chk_idle($sformatf("b%h after ack", b));
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.base_addr  = '0;
        bus.stride     = '0;
        bus.window_ack = 1'b0;

        // Reset values
        tick();
        tick();
        chk_idle("reset");
        chk("reset addr", 64'(bus.mem_addr), 64'd0);
        chk("reset idx",  64'(bus.row_idx),  64'd0);
        reset = 1'b0;
        tick();
        chk_idle("post reset");

        // Basic fetch with 5-cycle ack delay
        do_fetch(16'h0100, 16'h0010, 1'b0, 5, 1'b0);

        // Address wrap; stray starts/ack while busy; start together with ack
        do_fetch(16'hFFF0, 16'h0008, 1'b1, 0, 1'b1);

        // New start the cycle right after the start+ack cycle
        do_fetch(16'h0200, 16'h0004, 1'b0, 1, 1'b0);

        // Reset mid-fetch at T+8
        bus.base_addr = 16'h0300;
        bus.stride    = 16'h0001;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int o = 1; o <= 8; o++) begin
            chk($sformatf("rst o%0d rd_en", o), 64'(bus.mem_rd_en), 64'd1);
            if (o == 8) reset = 1'b1;
            tick();
        end
        reset   = 1'b0;
        exp_row = '0;
        chk_idle("mid reset");
        chk("mid reset addr", 64'(bus.mem_addr), 64'd0);
        chk("mid reset idx",  64'(bus.row_idx),  64'd0);
        for (int c = 0; c < 12; c++) begin
            tick();
            chk_idle($sformatf("after reset c%0d", c));
        end

        // Stride zero, also the clean fetch following the reset
        do_fetch(16'h0042, 16'h0000, 1'b0, 2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
